uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NREQ byte-stream requesters, e.g. the firmware Wishbone TX path and hardware producers.
- Per-byte round-robin arbitration, with an optional packet lock so multi-byte messages stay contiguous.
- Sequences the transmitter's start/clear handshake and bounds it with a timeout.
- Sits between the requesters and the UART TX engine (o_tx / o_tx_start / i_tx_start_clear / i_tx_busy).

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, register map and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [31:0] UART_RX_ADDR   = 32'h3000_0000;
    localparam logic [31:0] UART_TX_ADDR   = 32'h3000_0004;
    localparam logic [31:0] UART_STAT_ADDR = 32'h3000_0008;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or above ptr, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          found
);

    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the entry closest to ptr is written last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
        found = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte requesters: per-byte round robin,
// optional packet lock with a burst cap, and a timeout on the start handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [BYTE_W*NREQ-1:0]   i_req_data,
    input  logic [NREQ-1:0]          i_req_lock,
    output logic [NREQ-1:0]          o_req_pop,
    output logic [NREQ-1:0]          o_grant,
    output logic [BYTE_W-1:0]        o_tx,
    output logic                     o_tx_start,
    input  logic                     i_tx_start_clear,
    input  logic                     i_tx_busy,
    output logic                     o_busy,
    output logic                     o_timeout_err,
    input  logic                     i_err_clr
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e     state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  owner;
    logic [BW-1:0]  burst_cnt;
    logic [TW-1:0]  tmo_cnt;

    logic [NREQ-1:0]              pick_grant;
    logic                         pick_found;
    logic [PW-1:0]                pick_idx;
    logic [PW-1:0]                next_ptr;
    logic                         regrant;
    logic [NREQ-1:0][BYTE_W-1:0]  req_bytes;

    assign req_bytes = i_req_data;

    rr_picker #(.N(NREQ), .PW(PW)) u_pick (
        .valid (i_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .found (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick_grant[i]) pick_idx = PW'(i);
    end

    assign next_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign regrant  = i_req_lock[owner] && i_req_valid[owner] && (burst_cnt < BW'(MAX_BURST));
    assign o_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            burst_cnt     <= '0;
            tmo_cnt       <= '0;
            o_req_pop     <= '0;
            o_grant       <= '0;
            o_tx          <= '0;
            o_tx_start    <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_req_pop <= '0;
            // A timeout set later in this block overrides the clear.
            if (i_err_clr) o_timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found && !i_tx_busy) begin
                        owner      <= pick_idx;
                        o_grant    <= pick_grant;
                        o_req_pop  <= pick_grant;
                        o_tx       <= req_bytes[pick_idx];
                        o_tx_start <= 1'b1;
                        burst_cnt  <= BW'(1);
                        tmo_cnt    <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (i_tx_start_clear) begin
                        o_tx_start <= 1'b0;
                        state      <= WAIT_DONE;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        o_tx_start    <= 1'b0;
                        o_timeout_err <= 1'b1;
                        o_grant       <= '0;
                        rr_ptr        <= next_ptr;
                        burst_cnt     <= '0;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (regrant) begin
                            o_tx       <= req_bytes[owner];
                            o_req_pop  <= o_grant;
                            o_tx_start <= 1'b1;
                            burst_cnt  <= burst_cnt + 1'b1;
                            tmo_cnt    <= '0;
                            state      <= START;
                        end else begin
                            o_grant   <= '0;
                            rr_ptr    <= next_ptr;
                            burst_cnt <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester/transmitter models plus an ordered grant scoreboard.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int LIMIT = 2000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      i_req_valid;
    logic [8*NREQ-1:0]    i_req_data;
    logic [NREQ-1:0]      i_req_lock;
    logic [NREQ-1:0]      o_req_pop;
    logic [NREQ-1:0]      o_grant;
    logic [7:0]           o_tx;
    logic                 o_tx_start;
    logic                 i_tx_start_clear;
    logic                 i_tx_busy;
    logic                 o_busy;
    logic                 o_timeout_err;
    logic                 i_err_clr;

    logic model_busy, force_busy, tx_clr_en;
    assign i_tx_busy = model_busy | force_busy;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(4), .TIMEOUT(15)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (i_req_valid),
        .i_req_data       (i_req_data),
        .i_req_lock       (i_req_lock),
        .o_req_pop        (o_req_pop),
        .o_grant          (o_grant),
        .o_tx             (o_tx),
        .o_tx_start       (o_tx_start),
        .i_tx_start_clear (i_tx_start_clear),
        .i_tx_busy        (i_tx_busy),
        .o_busy           (o_busy),
        .o_timeout_err    (o_timeout_err),
        .i_err_clr        (i_err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] b;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] src_mem[NREQ][16];
    int         src_len[NREQ];
    int         src_pos[NREQ];
    logic [NREQ-1:0] lock_en;
    int n_assert, n_fail, pop_total, start_total, exp_total, pops_before;
    logic prev_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input logic [7:0] first, input int n, input logic lk);
        for (int k = 0; k < n; k++) src_mem[r][k] = first + 8'(k);
        src_pos[r] = 0;
        src_len[r] = n;
        lock_en[r] = lk;
    endtask

    task automatic expect_b(input int r, input logic [7:0] b);
        exp_t e;
        e.idx = 2'(r);
        e.b   = b;
        sb.push_back(e);
        exp_total++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pop"},   32'(o_req_pop),     32'h0);
        chk({tag, "_grant"}, 32'(o_grant),       32'h0);
        chk({tag, "_tx"},    32'(o_tx),          32'h0);
        chk({tag, "_start"}, 32'(o_tx_start),    32'h0);
        chk({tag, "_busy"},  32'(o_busy),        32'h0);
        chk({tag, "_err"},   32'(o_timeout_err), 32'h0);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!(sb.size() == 0 && !o_busy && !i_tx_busy) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_in_time"}, 32'(t < LIMIT), 32'h1);
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (!o_tx_start && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_start_in_time"}, 32'(t < 200), 32'h1);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        i_req_valid = '0; i_req_data = '0; i_req_lock = '0;
        i_tx_start_clear = 1'b0; i_err_clr = 1'b0;
        model_busy = 1'b0; force_busy = 1'b0; tx_clr_en = 1'b1;
        lock_en = '0; prev_start = 1'b0;
        n_assert = 0; n_fail = 0; pop_total = 0; start_total = 0; exp_total = 0;
        for (int i = 0; i < NREQ; i++) begin src_len[i] = 0; src_pos[i] = 0; end

        fork
            // requester model + output monitor
            forever begin
                exp_t e;
                logic rise;
                logic [NREQ-1:0] exp_pop;
                @(negedge clk);
                rise = o_tx_start && !prev_start;
                exp_pop = '0;
                if (rise) begin
                    start_total++;
                    chk("sb_nonempty", 32'(sb.size() > 0), 32'h1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        exp_pop = NREQ'(1) << e.idx;
                        chk("grant", 32'(o_grant), 32'(exp_pop));
                        chk("tx_byte", 32'(o_tx), 32'(e.b));
                    end
                end
                if (rise || o_req_pop != '0) chk("pop_vs_start", 32'(o_req_pop), 32'(exp_pop));
                pop_total += $countones(o_req_pop);
                prev_start = o_tx_start;
                for (int i = 0; i < NREQ; i++) if (o_req_pop[i]) src_pos[i]++;
                for (int i = 0; i < NREQ; i++) begin
                    i_req_valid[i] = (src_pos[i] < src_len[i]);
                    i_req_data[i*8 +: 8] = (src_pos[i] < 16) ? src_mem[i][src_pos[i]] : 8'h00;
                    i_req_lock[i] = lock_en[i] && i_req_valid[i];
                end
            end
            // transmitter model: clear 2 cycles after start, then busy for 10 cycles
            forever begin
                @(negedge clk);
                if (o_tx_start && tx_clr_en) begin
                    @(negedge clk);
                    i_tx_start_clear = 1'b1;
                    @(negedge clk);
                    i_tx_start_clear = 1'b0;
                    model_busy = 1'b1;
                    repeat (10) @(negedge clk);
                    model_busy = 1'b0;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // round-robin fairness
        expect_b(0, 8'h10); expect_b(1, 8'h20); expect_b(2, 8'h30); expect_b(3, 8'h40); expect_b(0, 8'h11);
        load(0, 8'h10, 2, 1'b0); load(1, 8'h20, 1, 1'b0); load(2, 8'h30, 1, 1'b0); load(3, 8'h40, 1, 1'b0);
        wait_done("rr");
        chk("rr_pop_count", 32'(pop_total), 32'd5);

        // packet lock: requester 2 keeps the grant for its three bytes
        expect_b(2, 8'hA1); expect_b(2, 8'hA2); expect_b(2, 8'hA3); expect_b(0, 8'h55);
        load(2, 8'hA1, 3, 1'b1); load(0, 8'h55, 1, 1'b0);
        cnt = 0;
        while (o_grant != 4'b0001 && cnt < LIMIT) begin @(negedge clk); cnt++; end
        chk("lock_req0_served", 32'(o_grant), 32'h1);
        chk("lock_rr_ptr", 32'(dut.rr_ptr), 32'd3);
        wait_done("lock");
        lock_en = '0;

        // burst limit: 4 locked bytes, then requester 3 once, then requester 1 resumes
        for (int k = 0; k < 4; k++) expect_b(1, 8'hB0 + 8'(k));
        expect_b(3, 8'hC0);
        for (int k = 4; k < 10; k++) expect_b(1, 8'hB0 + 8'(k));
        load(1, 8'hB0, 10, 1'b1); load(3, 8'hC0, 1, 1'b0);
        wait_done("burst");
        lock_en = '0;

        // start timeout
        tx_clr_en = 1'b0;
        expect_b(2, 8'hD0); expect_b(3, 8'hD1);
        load(2, 8'hD0, 1, 1'b0); load(3, 8'hD1, 1, 1'b0);
        wait_start("tmo");
        cnt = 0;
        while (o_tx_start && cnt < 100) begin cnt++; @(negedge clk); end
        chk("tmo_start_cycles", 32'(cnt), 32'd15);
        chk("tmo_err_set", 32'(o_timeout_err), 32'h1);
        chk("tmo_idle", 32'(o_busy), 32'h0);
        chk("tmo_grant_dropped", 32'(o_grant), 32'h0);
        tx_clr_en = 1'b1;
        @(negedge clk);
        chk("tmo_next_grant", 32'(o_grant), 32'h8);
        wait_done("tmo");
        chk("tmo_err_sticky", 32'(o_timeout_err), 32'h1);
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        chk("tmo_err_cleared", 32'(o_timeout_err), 32'h0);

        // busy gating
        force_busy = 1'b1;
        expect_b(1, 8'hE1);
        load(1, 8'hE1, 1, 1'b0);
        repeat (5) @(negedge clk);
        chk("gate_no_grant", 32'(o_grant), 32'h0);
        chk("gate_no_start", 32'(o_tx_start), 32'h0);
        chk("gate_idle", 32'(o_busy), 32'h0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("gate_start_1cyc", 32'(o_tx_start), 32'h1);
        chk("gate_grant", 32'(o_grant), 32'h2);
        wait_done("gate");

        // asynchronous reset in START, then restart from requester 0
        tx_clr_en = 1'b0;
        expect_b(2, 8'hE2); expect_b(0, 8'hE0); expect_b(3, 8'hE3);
        load(2, 8'hE2, 1, 1'b0); load(0, 8'hE0, 1, 1'b0); load(3, 8'hE3, 1, 1'b0);
        wait_start("rst_mid");
        chk("rst_mid_grant", 32'(o_grant), 32'h4);
        @(posedge clk);
        pops_before = pop_total;
        #3 rst_n = 1'b0;
        #1 check_reset("rst_async");
        repeat (3) @(negedge clk);
        chk("rst_no_extra_pop", 32'(pop_total), 32'(pops_before));
        tx_clr_en = 1'b1;
        rst_n = 1'b1;
        wait_done("rst_restart");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        chk("pop_total", 32'(pop_total), 32'(exp_total));
        chk("start_total", 32'(start_total), 32'(exp_total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
